// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch controller.
package fetch_pkg;

  // Default number of fetch buffer entries (also the in-flight + buffered limit).
  localparam int FETCH_DEPTH_DEFAULT = 4;

  // RUN: normal operation. DRAIN: responses to flushed requests are still due.
  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } fetch_state_e;

  // One fetch buffer slot: the request PC, the returned instruction and
  // whether the instruction has arrived yet (0 = request still pending).
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        filled;
  } fetch_entry_t;

endpackage

// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch controller: issues PC-addressed memory requests, reserves a
// buffer slot per request, fills slots from in-order responses and hands
// filled slots to decode. A flush empties the buffer and counts the responses
// still owed so they can be dropped when they come back.
module inst_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int DEPTH = FETCH_DEPTH_DEFAULT
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] pc_if1,
  output logic        pc_en,
  input  logic        flush,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  fetch_entry_t  entry_q [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [PW-1:0] fill_q, fill_d;
  logic [CW-1:0] count_q, count_d;   // slots in use (pending + filled)
  logic [CW-1:0] pend_q, pend_d;     // slots still waiting for their response
  logic [CW-1:0] stale_q, stale_d;   // responses owed to flushed requests
  fetch_state_e  state_q, state_d;

  fetch_entry_t  head_entry;
  logic [CW-1:0] owed;
  logic          space_ok;
  logic          req_fire;
  logic          pop;
  logic          rsp_live;
  logic          rsp_stale;

  // Stale responses still occupy the memory pipeline, so they count against DEPTH.
  assign space_ok       = (count_q + stale_q) < DEPTH_C;
  assign imem_req_addr  = pc_if1;
  assign imem_req_valid = reset_n & ~flush & space_ok;
  assign req_fire       = imem_req_valid & imem_req_ready;
  assign pc_en          = reset_n & (req_fire | flush);

  assign head_entry = entry_q[head_q];
  assign id_valid   = reset_n & ~flush & head_entry.filled & (count_q != '0);
  assign id_inst    = head_entry.inst;
  assign id_pc      = head_entry.pc;
  assign pop        = id_valid & id_ready;

  // Responses are in order, so every owed stale response precedes live ones.
  assign rsp_stale = imem_rsp_valid & (stale_q != '0);
  assign rsp_live  = imem_rsp_valid & ~flush & (stale_q == '0) & (pend_q != '0);
  assign owed      = stale_q + pend_q;

  // Pointer and occupancy next-state: request, fill and pop move independently.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    fill_d  = fill_q;
    count_d = count_q;
    pend_d  = pend_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      fill_d  = '0;
      count_d = '0;
      pend_d  = '0;
    end else begin
      if (req_fire) tail_d = tail_q + PTR_ONE;
      if (rsp_live) fill_d = fill_q + PTR_ONE;
      if (pop)      head_d = head_q + PTR_ONE;
      count_d = count_q + (req_fire ? CNT_ONE : '0) - (pop ? CNT_ONE : '0);
      pend_d  = pend_q + (req_fire ? CNT_ONE : '0) - (rsp_live ? CNT_ONE : '0);
    end
  end

  // FSM next-state: a flush re-counts what is owed (less any response landing
  // in the flush cycle itself); DRAIN counts stale responses down to zero.
  always_comb begin
    state_d = state_q;
    stale_d = stale_q;
    if (flush) begin
      stale_d = (imem_rsp_valid && (owed != '0)) ? (owed - CNT_ONE) : owed;
      state_d = (stale_d != '0) ? ST_DRAIN : ST_RUN;
    end else begin
      case (state_q)
        ST_RUN: begin
          state_d = ST_RUN;
        end
        ST_DRAIN: begin
          if (rsp_stale) begin
            stale_d = stale_q - CNT_ONE;
            if (stale_q == CNT_ONE) state_d = ST_RUN;
          end
        end
      endcase
    end
  end

  // FSM state and stale counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_RUN;
      stale_q <= '0;
    end else begin
      state_q <= state_d;
      stale_q <= stale_d;
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      fill_q  <= '0;
      count_q <= '0;
      pend_q  <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      fill_q  <= fill_d;
      count_q <= count_d;
      pend_q  <= pend_d;
    end
  end

  // Buffer slots: reserve at the tail, fill the oldest pending, retire the head.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) entry_q[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) entry_q[i].filled <= 1'b0;
    end else begin
      if (req_fire) entry_q[tail_q] <= {pc_if1, 32'h0, 1'b0};
      if (rsp_live) begin
        entry_q[fill_q].inst   <= imem_rsp_data;
        entry_q[fill_q].filled <= 1'b1;
      end
      if (pop) entry_q[head_q].filled <= 1'b0;
    end
  end

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Bench for inst_fetch_ctrl: queue-based reference model of the fetch
// buffer, an in-order memory model, directed scenarios and a random phase.
module tb_inst_fetch_ctrl;

  localparam int          DEPTH   = 4;
  localparam logic [31:0] BOOT_PC = 32'h8000_0000;
  localparam logic [31:0] KEY     = 32'h5A5A_5A5A;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [31:0] pc_if1 = BOOT_PC;
  logic        pc_en;
  logic        flush = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'h0;
  logic        id_valid;
  logic        id_ready = 1'b0;
  logic [31:0] id_inst;
  logic [31:0] id_pc;

  always #5 clk = ~clk;

  inst_fetch_ctrl #(.DEPTH(DEPTH)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .pc_if1         (pc_if1),
    .pc_en          (pc_en),
    .flush          (flush),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_inst        (id_inst),
    .id_pc          (id_pc)
  );

  // Reference model: outstanding fetches in program order, plus a count of
  // responses still owed to flushed requests.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
    bit          filled;
  } ment_t;

  ment_t       mq[$];
  logic [31:0] mem_q[$];
  int          m_stale = 0;
  logic [31:0] pc_nxt = BOOT_PC;
  logic [31:0] tgt = 32'h0;
  logic [31:0] next_tgt = 32'h0;
  int          rdy_pct = 0, idr_pct = 0, rsp_pct = 0, fl_pm = 0;
  int          errors = 0, checks = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
    end
  endtask

  // Advance model, memory and PC by one clock using the inputs that were
  // applied during the cycle that just ended.
  task automatic model_update();
    bit    fire, popv, done;
    int    owed;
    ment_t e;
    fire = !flush && (mq.size() + m_stale < DEPTH) && imem_req_ready;
    popv = 1'b0;
    if (!flush && mq.size() > 0) popv = mq[0].filled && id_ready;
    if (flush) begin
      owed = m_stale;
      foreach (mq[k]) if (!mq[k].filled) owed++;
      if (imem_rsp_valid && owed > 0) owed--;
      m_stale = owed;
      mq.delete();
    end else begin
      if (imem_rsp_valid) begin
        if (m_stale > 0) m_stale--;
        else begin
          done = 1'b0;
          for (int k = 0; k < mq.size(); k++) begin
            if (!done && !mq[k].filled) begin
              e = mq[k];
              e.data = imem_rsp_data;
              e.filled = 1'b1;
              mq[k] = e;
              done = 1'b1;
            end
          end
        end
      end
      if (popv) void'(mq.pop_front());
      if (fire) begin
        e.pc = pc_if1;
        e.data = 32'h0;
        e.filled = 1'b0;
        mq.push_back(e);
      end
    end
    if (imem_rsp_valid && mem_q.size() > 0) void'(mem_q.pop_front());
    if (fire) mem_q.push_back(pc_if1);
    if (flush) pc_nxt = tgt;
    else if (fire) pc_nxt = pc_if1 + 32'd4;
  endtask

  task automatic drive(input bit fl);
    pc_if1 = pc_nxt;
    imem_req_ready = ($urandom_range(99) < rdy_pct);
    id_ready = ($urandom_range(99) < idr_pct);
    imem_rsp_valid = 1'b0;
    imem_rsp_data = $urandom();
    if (mem_q.size() > 0 && $urandom_range(99) < rsp_pct) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data = mem_q[0] ^ KEY;
    end
    flush = fl || ($urandom_range(999) < fl_pm);
    tgt = fl ? next_tgt : ($urandom() & 32'hFFFF_FFFC);
  endtask

  task automatic step(input bit fl);
    @(posedge clk);
    model_update();
    #1;
    drive(fl);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    flush = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data = 32'h0;
    id_ready = 1'b0;
    mq.delete();
    mem_q.delete();
    m_stale = 0;
    pc_nxt = BOOT_PC;
    pc_if1 = BOOT_PC;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    drive(1'b0);
  endtask

  // Step until the first id_valid (bounded); lat = negedges waited, -1 if none.
  task automatic capture(input int budget, output logic [31:0] pc, output logic [31:0] inst,
                         output int lat);
    int i;
    pc = 32'hFFFF_FFFF;
    inst = 32'hFFFF_FFFF;
    lat = -1;
    i = 0;
    while (i < budget && lat < 0) begin
      @(negedge clk);
      if (id_valid) begin
        pc = id_pc;
        inst = id_inst;
        lat = i;
      end else begin
        step(1'b0);
      end
      i++;
    end
  endtask

  // Compare every cycle against the model, away from the active edge.
  always @(negedge clk) begin
    logic exp_rv, exp_iv;
    if (!reset_n) begin
      chk1("rst_id_valid", id_valid, 1'b0);
      chk1("rst_req_valid", imem_req_valid, 1'b0);
      chk1("rst_pc_en", pc_en, 1'b0);
    end else begin
      exp_rv = !flush && (mq.size() + m_stale < DEPTH);
      exp_iv = 1'b0;
      if (!flush && mq.size() > 0) exp_iv = mq[0].filled;
      chk1("req_valid", imem_req_valid, exp_rv);
      chk1("pc_en", pc_en, (exp_rv && imem_req_ready) || flush);
      chk("req_addr", imem_req_addr, pc_if1);
      chk1("id_valid", id_valid, exp_iv);
      if (exp_iv) begin
        chk("id_pc", id_pc, mq[0].pc);
        chk("id_inst", id_inst, mq[0].data);
        if (id_ready) $display("[%0t] decode pc=%h inst=%h", $time, id_pc, id_inst);
      end
    end
  end

  initial begin
    logic [31:0] cpc, cinst;
    int          lat, n;

    #2;
    // Reset release, 1-cycle memory: sequential PCs streaming one per cycle.
    rdy_pct = 100; idr_pct = 100; rsp_pct = 100; fl_pm = 0;
    do_reset();
    @(negedge clk);
    chk("boot_addr", imem_req_addr, BOOT_PC);
    chk1("boot_req_valid", imem_req_valid, 1'b1);
    for (int i = 0; i < 8; i++) begin
      step(1'b0);
      @(negedge clk);
      if (i == 0) chk1("first_latency_idv", id_valid, 1'b0);
      else begin
        chk1("stream_idv", id_valid, 1'b1);
        chk("stream_pc", id_pc, BOOT_PC + 32'(4 * (i - 1)));
        chk("stream_inst", id_inst, (BOOT_PC + 32'(4 * (i - 1))) ^ KEY);
      end
    end

    // Decode stalled: exactly DEPTH requests, then one per pop.
    idr_pct = 0;
    do_reset();
    n = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (imem_req_valid && imem_req_ready) n++;
      step(1'b0);
    end
    chk("stall_accepted", 32'(n), 32'd4);
    @(negedge clk);
    chk1("stall_req_valid", imem_req_valid, 1'b0);
    chk1("stall_pc_en", pc_en, 1'b0);
    idr_pct = 100;
    step(1'b0);
    @(negedge clk);
    chk1("stall_pop_idv", id_valid, 1'b1);
    chk1("stall_pop_req_still_0", imem_req_valid, 1'b0);
    idr_pct = 0;
    step(1'b0);
    @(negedge clk);
    chk1("stall_refill_req", imem_req_valid, 1'b1);
    step(1'b0);
    @(negedge clk);
    chk1("stall_full_again", imem_req_valid, 1'b0);

    // Flush with two requests in flight: both responses dropped.
    rdy_pct = 100; idr_pct = 100; rsp_pct = 0;
    do_reset();
    step(1'b0);
    rdy_pct = 0;
    step(1'b0);
    next_tgt = 32'h1000_0000;
    step(1'b1);
    @(negedge clk);
    chk1("flush_pc_en", pc_en, 1'b1);
    chk1("flush_no_req", imem_req_valid, 1'b0);
    rdy_pct = 100; rsp_pct = 100;
    step(1'b0);
    chk("drain_model_stale", 32'(m_stale), 32'd2);
    capture(12, cpc, cinst, lat);
    chk("drain_first_pc", cpc, 32'h1000_0000);
    chk("drain_first_inst", cinst, 32'h1000_0000 ^ KEY);
    chk("drain_latency", 32'(lat), 32'd3);

    // Response arriving in the flush cycle is discarded.
    rdy_pct = 100; idr_pct = 100; rsp_pct = 0;
    do_reset();
    rdy_pct = 0;
    step(1'b0);
    rsp_pct = 100; next_tgt = 32'h2000_0000;
    step(1'b1);
    @(negedge clk);
    chk1("rspflush_idv", id_valid, 1'b0);
    rdy_pct = 100;
    step(1'b0);
    chk("rspflush_model_stale", 32'(m_stale), 32'd0);
    capture(12, cpc, cinst, lat);
    chk("rspflush_first_pc", cpc, 32'h2000_0000);
    chk("rspflush_latency", 32'(lat), 32'd2);

    // Simultaneous pop, response and request with three slots in use.
    rdy_pct = 100; idr_pct = 0; rsp_pct = 0;
    do_reset();
    step(1'b0);
    step(1'b0);
    rdy_pct = 0;
    step(1'b0);
    rsp_pct = 100;
    step(1'b0);
    rdy_pct = 100; idr_pct = 100;
    step(1'b0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk1("concur_idv", id_valid, 1'b1);
      chk1("concur_req", imem_req_valid, 1'b1);
      chk("concur_pc", id_pc, BOOT_PC + 32'(4 * i));
      step(1'b0);
    end

    // Reset asserted while draining.
    rdy_pct = 100; idr_pct = 100; rsp_pct = 0;
    do_reset();
    step(1'b0);
    rdy_pct = 0;
    step(1'b0);
    next_tgt = 32'h3000_0000;
    step(1'b1);
    step(1'b0);
    chk("rstdrain_model_stale", 32'(m_stale), 32'd2);
    reset_n = 1'b0;
    #1;
    chk1("rstdrain_idv", id_valid, 1'b0);
    chk1("rstdrain_req", imem_req_valid, 1'b0);
    chk1("rstdrain_pc_en", pc_en, 1'b0);
    rdy_pct = 100; rsp_pct = 100;
    do_reset();
    #1;
    chk("rstdrain_boot_addr", imem_req_addr, BOOT_PC);
    chk1("rstdrain_boot_req", imem_req_valid, 1'b1);
    capture(12, cpc, cinst, lat);
    chk("rstdrain_first_pc", cpc, BOOT_PC);
    chk("rstdrain_latency", 32'(lat), 32'd2);

    // Randomized traffic with random flushes.
    fl_pm = 0;
    do_reset();
    for (int seg = 0; seg < 30; seg++) begin
      rdy_pct = int'($urandom_range(100, 20));
      idr_pct = int'($urandom_range(100, 10));
      rsp_pct = int'($urandom_range(100, 20));
      fl_pm   = int'($urandom_range(60, 0));
      repeat (100) step(1'b0);
    end

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
